// File: rtl/ktc32_uart_tx_if.sv
// ktc32 data-bus slice seen by the UART transmitter: address, write data,
// write size, and the registered read data / hit returned to the read mux.
interface ktc32_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [1:0]  memwrite;
  logic [31:0] rd;
  logic        hit;

  modport master (
    output addr,
    output wd,
    output memwrite,
    input  rd,
    input  hit
  );

  modport slave (
    input  addr,
    input  wd,
    input  memwrite,
    output rd,
    output hit
  );
endinterface

// File: rtl/ktc32_uart_tx.sv
// Memory-mapped UART transmitter for the ktc32 data bus.
// Window of 8 bytes at BASE_ADDR: DATA (addr[2]=0) pushes a byte into the
// transmit FIFO, STATUS (addr[2]=1) reads state and clears the sticky overflow.
// Frames are 8N1, or 8E1 when KTC32_UART_TX_PARITY_EN is defined.
module ktc32_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  ktc32_uart_tx_if.slave bus,
  output logic           txd,
  output logic           irq
);

  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned DIVW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef KTC32_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
`ifdef KTC32_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PTRW-1:0] wptr_q, rptr_q;
  logic [CNTW-1:0] count_q;
  logic            ovf_q;
  logic [31:0]     rd_q;
  logic            hit_q;
  logic            irq_q;

  logic        sel, wr_any, push_req, clr_ovf;
  logic        full, empty, busy;
  logic        pop, push, drop;
  logic        bit_end;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_bus;

  assign sel      = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign wr_any   = (bus.memwrite != 2'b00);
  assign push_req = sel & ~bus.addr[2] & wr_any;
  assign clr_ovf  = sel & bus.addr[2] & wr_any;
  // Byte lanes other than 0 and the low address bits carry no meaning here.
  assign unused_bus = ^{bus.addr[1:0], bus.wd[31:8]};

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign busy  = (state_q != StIdle);
  assign head  = mem_q[rptr_q];

  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  assign bit_end = (div_q == DIV_LAST);

  // Transmitter state register; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef KTC32_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef KTC32_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, pop request and the line level for the following cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
`ifdef KTC32_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef KTC32_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          div_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef KTC32_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef KTC32_UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = StStop;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // txd is registered, so it is derived from where the FSM is going.
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef KTC32_UART_TX_PARITY_EN
      StParity: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      ovf_q <= (ovf_q & ~clr_ovf) | drop;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wd[7:0];
  end

  // STATUS word assembled from the current-cycle state.
  always_comb begin
    status            = '0;
    status[0]         = busy;
    status[1]         = full;
    status[2]         = empty;
    status[3]         = ovf_q;
    status[4 +: CNTW] = count_q;
`ifdef KTC32_UART_TX_PARITY_EN
    status[31]        = 1'b1;
`endif
  end

  // Registered read return, hit qualifier and level interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      hit_q <= 1'b0;
      irq_q <= 1'b1;
    end else begin
      rd_q  <= (sel && bus.addr[2]) ? status : 32'h0;
      hit_q <= sel;
      irq_q <= empty & ~busy;
    end
  end

  assign bus.rd  = rd_q;
  assign bus.hit = hit_q;
  assign txd     = txd_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_ktc32_uart_tx.sv
// Self-checking bench for ktc32_uart_tx: a frame-timeline model checked every
// cycle, plus directed checks with hand-computed frames and STATUS words.
module tb_ktc32_uart_tx;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
`ifdef KTC32_UART_TX_PARITY_EN
  localparam int          FB     = 11;
  localparam logic [31:0] PARBIT = 32'h8000_0000;
  localparam logic [31:0] FR_A5  = 32'h0000_054A;
`else
  localparam int          FB     = 10;
  localparam logic [31:0] PARBIT = 32'h0000_0000;
  localparam logic [31:0] FR_A5  = 32'h0000_034A;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd;
  logic irq;

  ktc32_uart_tx_if bus_if ();

  ktc32_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if),
    .txd  (txd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  mq[$];
  bit          m_ovf;
  bit          m_busy;
  int          m_t;
  logic [7:0]  m_cur;
  logic        m_irq;
  logic        m_hit;
  logic [31:0] m_rd;

  function automatic logic [31:0] status_word(bit busy, int cnt, bit ovf);
    logic [31:0] s;
    s = PARBIT;
    s[0] = busy;
    s[1] = (cnt == DEPTH);
    s[2] = (cnt == 0);
    s[3] = ovf;
    s = s | (32'(cnt) << 4);
    return s;
  endfunction

  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef KTC32_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_t    = 0;
        m_irq  = 1'b1;
        m_hit  = 1'b0;
        m_rd   = 32'h0;
      end else begin
        int cnt;
        bit pop, sel, req, clr;
        cnt = mq.size();
        sel = (bus_if.addr[31:3] == BASE[31:3]);
        req = sel && !bus_if.addr[2] && (bus_if.memwrite != 2'b00);
        clr = sel && bus_if.addr[2] && (bus_if.memwrite != 2'b00);
        m_hit = sel;
        m_rd  = (sel && bus_if.addr[2]) ? status_word(m_busy, cnt, m_ovf) : 32'h0;
        m_irq = (cnt == 0) && !m_busy;
        pop   = !m_busy && (cnt > 0);
        if (m_busy) begin
          m_t++;
          if (m_t == FB * CPB) m_busy = 1'b0;
        end else if (pop) begin
          m_cur  = mq.pop_front();
          m_busy = 1'b1;
          m_t    = 0;
        end
        if (clr) m_ovf = 1'b0;
        if (req) begin
          if (cnt < DEPTH || pop) mq.push_back(bus_if.wd[7:0]);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("txd", {31'h0, txd}, {31'h0, m_busy ? frame_bit(m_cur, m_t / CPB) : 1'b1});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        check("hit", {31'h0, bus_if.hit}, {31'h0, m_hit});
        check("rd", bus_if.rd, m_rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
    @(posedge clk);
    #1;
    bus_if.addr     = a;
    bus_if.wd       = d;
    bus_if.memwrite = mw;
  endtask

  task automatic bus_idle();
    @(posedge clk);
    #1;
    bus_if.addr     = 32'h0;
    bus_if.wd       = 32'h0;
    bus_if.memwrite = 2'b00;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] r, output logic h);
    @(posedge clk);
    #1;
    bus_if.addr     = a;
    bus_if.memwrite = 2'b00;
    @(posedge clk);
    #1;
    bus_if.addr = 32'h0;
    @(negedge clk);
    r = bus_if.rd;
    h = bus_if.hit;
  endtask

  // Samples each serial bit mid-period, starting at the next start bit.
  task automatic capture_frame(output logic [FB-1:0] bits);
    int n;
    int cur;
    n    = 0;
    bits = '0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("capture_start", {31'h0, (n < 2000)}, 32'h1);
    if (n < 2000) begin
      cur = 0;
      for (int i = 0; i < FB; i++) begin
        repeat (i * CPB + CPB / 2 - cur) @(negedge clk);
        cur = i * CPB + CPB / 2;
        bits[i] = txd;
      end
    end
  endtask

  task automatic wait_irq(input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("irq_idle", {31'h0, irq}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  logic [FB-1:0] fr, fr2;
  logic [31:0]   r;
  logic          h;
  int            n;

  initial begin
    bus_if.addr     = 32'h0;
    bus_if.wd       = 32'h0;
    bus_if.memwrite = 2'b00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h1);
    read_reg(BASE + 32'h4, r, h);
    check("reset_status", r, 32'h0000_0004 | PARBIT);
    check("reset_status_hit", {31'h0, h}, 32'h1);

    // Single byte, byte-size write.
    fork
      capture_frame(fr);
      begin
        wr(BASE, 32'h0000_00A5, 2'b01);
        bus_idle();
        repeat (3) @(negedge clk);
        check("irq_fall", {31'h0, irq}, 32'h0);
      end
    join
    check("frame_a5", 32'(fr), FR_A5);
    wait_irq(200);

    // Word-size write only sends the low byte.
    fork
      capture_frame(fr);
      begin
        wr(BASE, 32'h1234_5678, 2'b11);
        bus_idle();
      end
    join
    check("word_byte", {24'h0, fr[8:1]}, 32'h78);
    wait_irq(200);

    // Overflow: 18 back-to-back writes, the first is popped after one cycle.
    for (int i = 0; i < 18; i++) wr(BASE, 32'h40 + i, 2'b01);
    read_reg(BASE + 32'h4, r, h);
    check("ovf_status", r, 32'h0000_010B | PARBIT);
    wr(BASE + 32'h4, 32'hFFFF_FFFF, 2'b10);
    read_reg(BASE + 32'h4, r, h);
    check("ovf_cleared", r, 32'h0000_0103 | PARBIT);
    wait_irq(1500);

    // Push in the very cycle the transmitter pops the only entry.
    fork
      begin
        capture_frame(fr);
        capture_frame(fr2);
      end
      begin
        wr(BASE, 32'h3C, 2'b01);
        wr(BASE, 32'hC3, 2'b01);
        read_reg(BASE + 32'h4, r, h);
        check("pushpop_status", r, 32'h0000_0011 | PARBIT);
      end
    join
    check("pushpop_first", {24'h0, fr[8:1]}, 32'h3C);
    check("pushpop_second", {24'h0, fr2[8:1]}, 32'hC3);
    wait_irq(200);

    // Window decode.
    read_reg(BASE + 32'h8, r, h);
    check("outside_hit", {31'h0, h}, 32'h0);
    check("outside_rd", r, 32'h0);
    read_reg(BASE, r, h);
    check("data_read_hit", {31'h0, h}, 32'h1);
    check("data_read_rd", r, 32'h0);
    read_reg(BASE + 32'h7, r, h);
    check("status_alias", r, 32'h0000_0004 | PARBIT);

    // Reset in the middle of the data bits.
    wr(BASE, 32'h00, 2'b01);
    wr(BASE, 32'h55, 2'b01);
    bus_idle();
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_start_seen", {31'h0, (n < 100)}, 32'h1);
    repeat (CPB + 2) @(negedge clk);
    check("abort_pre_txd", {31'h0, txd}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_txd", {31'h0, txd}, 32'h1);
    check("abort_irq", {31'h0, irq}, 32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    read_reg(BASE + 32'h4, r, h);
    check("abort_status", r, 32'h0000_0004 | PARBIT);
    repeat (20) @(negedge clk);
    check("abort_idle_txd", {31'h0, txd}, 32'h1);

`ifdef KTC32_UART_TX_PARITY_EN
    fork
      capture_frame(fr);
      begin
        wr(BASE, 32'h07, 2'b01);
        bus_idle();
      end
    join
    check("parity_frame", 32'(fr), 32'h0000_060E);
    wait_irq(200);
    read_reg(BASE + 32'h4, r, h);
    check("parity_bit31", {31'h0, r[31]}, 32'h1);
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
